// File: rtl/forward_kin.sv
// Forward-kinematics solver for a two-link planar arm.
// Computes the tool tip x = L1*cos(t1) + L2*cos(t1+t2) and y = L1*sin(t1) + L2*sin(t1+t2)
// with one sequential 16-iteration CORDIC rotator that is reused for both links.
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   start        solve request, sampled only while idle
//   xita1, xita2 joint angles, signed Q16.16 rad
//   busy         high while a solve is in flight
//   valid        one-cycle pulse when x/y are updated
//   x, y         tip position, signed Q16.16 cm, held until the next result
module forward_kin #(
    parameter logic [31:0] L1 = 32'h0007_6666,
    parameter logic [31:0] L2 = 32'h0012_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] xita1,
    input  logic [31:0] xita2,
    output logic        busy,
    output logic        valid,
    output logic [31:0] x,
    output logic [31:0] y
);

    localparam int unsigned DW   = 34;
    localparam int unsigned IW   = 4;
    localparam int unsigned ITER = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD1 = 3'd1;
    localparam logic [2:0] S_ROT1  = 3'd2;
    localparam logic [2:0] S_LOAD2 = 3'd3;
    localparam logic [2:0] S_ROT2  = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;

    localparam logic [31:0] K_GAIN = 32'h0000_9B75;

    // Link lengths pre-scaled by the inverse CORDIC gain, folded at elaboration.
    localparam logic [63:0]          LK1_P = (64'(L1) * 64'(K_GAIN)) >> 16;
    localparam logic [63:0]          LK2_P = (64'(L2) * 64'(K_GAIN)) >> 16;
    localparam logic signed [DW-1:0] LK1   = $signed(DW'(LK1_P));
    localparam logic signed [DW-1:0] LK2   = $signed(DW'(LK2_P));

    localparam logic signed [DW-1:0] PI      = $signed(DW'(32'h0003_243F));
    localparam logic signed [DW-1:0] TWO_PI  = $signed(DW'(32'h0006_487F));
    localparam logic signed [DW-1:0] HALF_PI = $signed(DW'(32'h0001_921F));

    // atan(2^-i) in Q16.16
    function automatic logic signed [DW-1:0] atan_lut(input logic [IW-1:0] i);
        atan_lut = '0;
        case (i)
            4'd0:  atan_lut = $signed(DW'(51472));
            4'd1:  atan_lut = $signed(DW'(30386));
            4'd2:  atan_lut = $signed(DW'(16055));
            4'd3:  atan_lut = $signed(DW'(8150));
            4'd4:  atan_lut = $signed(DW'(4091));
            4'd5:  atan_lut = $signed(DW'(2047));
            4'd6:  atan_lut = $signed(DW'(1024));
            4'd7:  atan_lut = $signed(DW'(512));
            4'd8:  atan_lut = $signed(DW'(256));
            4'd9:  atan_lut = $signed(DW'(128));
            4'd10: atan_lut = $signed(DW'(64));
            4'd11: atan_lut = $signed(DW'(32));
            4'd12: atan_lut = $signed(DW'(16));
            4'd13: atan_lut = $signed(DW'(8));
            4'd14: atan_lut = $signed(DW'(4));
            4'd15: atan_lut = $signed(DW'(2));
        endcase
    endfunction

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [IW-1:0]        iter;
    logic signed [31:0]   ang1;
    logic signed [31:0]   ang2;
    logic signed [DW-1:0] xr;
    logic signed [DW-1:0] yr;
    logic signed [DW-1:0] zr;
    logic signed [DW-1:0] x1;
    logic signed [DW-1:0] y1;

    logic signed [DW-1:0] ang_sum;
    logic signed [DW-1:0] ang_sel;
    logic signed [DW-1:0] lk_sel;
    logic signed [DW-1:0] seed_x;
    logic signed [DW-1:0] seed_y;
    logic signed [DW-1:0] seed_z;
    logic signed [DW-1:0] rot_x;
    logic signed [DW-1:0] rot_y;
    logic signed [DW-1:0] rot_z;
    logic signed [DW-1:0] x_sh;
    logic signed [DW-1:0] y_sh;
    logic signed [DW-1:0] at_i;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD1;
            S_LOAD1: state_nxt = S_ROT1;
            S_ROT1:  if (iter == IW'(ITER - 1)) state_nxt = S_LOAD2;
            S_LOAD2: state_nxt = S_ROT2;
            S_ROT2:  if (iter == IW'(ITER - 1)) state_nxt = S_OUT;
            S_OUT:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Seed selection: link-2 angle is wrapped, then both are folded into [-pi/2, pi/2]
    always_comb begin
        ang_sum = $signed({{2{ang1[31]}}, ang1}) + $signed({{2{ang2[31]}}, ang2});
        if (ang_sum > PI) begin
            ang_sum = ang_sum - TWO_PI;
        end else if (ang_sum < -PI) begin
            ang_sum = ang_sum + TWO_PI;
        end
        ang_sel = (state == S_LOAD1) ? $signed({{2{ang1[31]}}, ang1}) : ang_sum;
        lk_sel  = (state == S_LOAD1) ? LK1 : LK2;
        seed_x  = lk_sel;
        seed_y  = '0;
        seed_z  = ang_sel;
        if (ang_sel > HALF_PI) begin
            seed_x = '0;
            seed_y = lk_sel;
            seed_z = ang_sel - HALF_PI;
        end else if (ang_sel < -HALF_PI) begin
            seed_x = '0;
            seed_y = -lk_sel;
            seed_z = ang_sel + HALF_PI;
        end
    end

    // One CORDIC micro-rotation; direction follows the sign of the residual angle
    always_comb begin
        x_sh = xr >>> iter;
        y_sh = yr >>> iter;
        at_i = atan_lut(iter);
        if (!zr[DW-1]) begin
            rot_x = xr - y_sh;
            rot_y = yr + x_sh;
            rot_z = zr - at_i;
        end else begin
            rot_x = xr + y_sh;
            rot_y = yr - x_sh;
            rot_z = zr + at_i;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            iter  <= '0;
            ang1  <= '0;
            ang2  <= '0;
            xr    <= '0;
            yr    <= '0;
            zr    <= '0;
            x1    <= '0;
            y1    <= '0;
            x     <= '0;
            y     <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            busy  <= (state_nxt != S_IDLE);
            valid <= (state == S_OUT);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ang1 <= xita1;
                        ang2 <= xita2;
                    end
                end
                S_LOAD1: begin
                    xr   <= seed_x;
                    yr   <= seed_y;
                    zr   <= seed_z;
                    iter <= '0;
                end
                S_LOAD2: begin
                    x1   <= xr;
                    y1   <= yr;
                    xr   <= seed_x;
                    yr   <= seed_y;
                    zr   <= seed_z;
                    iter <= '0;
                end
                S_ROT1, S_ROT2: begin
                    xr   <= rot_x;
                    yr   <= rot_y;
                    zr   <= rot_z;
                    iter <= iter + IW'(1);
                end
                S_OUT: begin
                    x <= 32'(x1 + xr);
                    y <= 32'(y1 + yr);
                end
                default: ;
            endcase
        end
    end

endmodule
